// File: rtl/alu_sched_pkg.sv
// Shared opcode constants and scheduler state encoding for alu_rr_scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_NOT  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-op ALU: NOT A, NAND, ADD with carry, full-width MUL.
// Results are zero-extended to 2*DATA_W bits.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [1:0]          op,
  output logic [2*DATA_W-1:0] res
);

  localparam int RES_W = 2 * DATA_W;

  // Logical results are formed at operand width so the upper half stays zero.
  logic [DATA_W-1:0] not_a;
  logic [DATA_W-1:0] nand_ab;

  assign not_a   = ~a;
  assign nand_ab = ~(a & b);

  always_comb begin
    res = '0;
    case (op)
      OP_NOT:  res = {{(RES_W-DATA_W){1'b0}}, not_a};
      OP_NAND: res = {{(RES_W-DATA_W){1'b0}}, nand_ab};
      OP_ADD:  res = RES_W'(a) + RES_W'(b);
      OP_MUL:  res = RES_W'(a) * RES_W'(b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one alu_core between two valid/ready requesters.
// Optional grant counters are enabled with `define ALU_RR_SCHED_STATS_EN.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int RES_W  = 2 * DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  state_t              state_reg, state_next;
  logic                last_reg;
  logic                id_reg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [1:0]          op_reg;
  logic [RES_W-1:0]    rsp_data_reg;
  logic [RES_W-1:0]    alu_res;
  logic                win0, win1;
  logic                take;
  logic                take_id;

  // Contention goes to the requester that was not granted last.
  assign win0 = req0_valid && (!req1_valid || last_reg);
  assign win1 = req1_valid && (!req0_valid || !last_reg);

  assign req0_ready = rst_n && (state_reg == IDLE) && win0;
  assign req1_ready = rst_n && (state_reg == IDLE) && win1;
  assign take       = req0_ready || req1_ready;
  assign take_id    = req1_ready;

  always_comb begin
    state_next = state_reg;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (take) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a   (a_reg),
    .b   (b_reg),
    .op  (op_reg),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      id_reg       <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        a_reg    <= take_id ? req1_a  : req0_a;
        b_reg    <= take_id ? req1_b  : req0_b;
        op_reg   <= take_id ? req1_op : req0_op;
        id_reg   <= take_id;
        last_reg <= take_id;
      end
      if (state_reg == EXEC) rsp_data_reg <= alu_res;
    end
  end

  assign rsp_id   = id_reg;
  assign rsp_data = rsp_data_reg;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [1:0]       grant_vec;
  logic [CNT_W-1:0] cnt_reg  [2];
  logic [CNT_W-1:0] cnt_next [2];

  assign grant_vec = {req1_ready, req0_ready};

  // Counters stick at all-ones instead of wrapping.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    assign cnt_next[gi] = (grant_vec[gi] && (cnt_reg[gi] != '1)) ?
                          cnt_reg[gi] + 1'b1 : cnt_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg[0] <= '0;
      cnt_reg[1] <= '0;
    end else begin
      cnt_reg[0] <= cnt_next[0];
      cnt_reg[1] <= cnt_next[1];
    end
  end

  assign grant_cnt0 = cnt_reg[0];
  assign grant_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomised and directed bench for alu_rr_scheduler against a cycle-level reference model.
module tb_alu_rr_scheduler;

  localparam int DW    = 2;
  localparam int RW    = 2 * DW;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [RW-1:0] rsp_data;
`ifdef ALU_RR_SCHED_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_rr_scheduler #(.DATA_W(DW), .RES_W(RW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef ALU_RR_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = waiting for work, 1 = computing, 2 = offering result
  int m_phase;
  int m_last;
  int m_id;
  int m_data;
  int m_cnt [2];
  bit m_zero;

  int acc_id, acc_data, n_acc;
  bit seen_r0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    int mask;
    mask = (1 << DW) - 1;
    case (op)
      0:       return (~a) & mask;
      1:       return (~(a & b)) & mask;
      2:       return a + b;
      default: return a * b;
    endcase
  endfunction

  task automatic step(input bit rn,
                      input bit v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [1:0] op0,
                      input bit v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [1:0] op1,
                      input bit rr);
    int win;
    @(negedge clk);
    rst_n = rn;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = rr;
    #1;
    win = -1;
    if (rn && m_phase == 0) begin
      if (v0 && v1) win = 1 - m_last;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    seen_r0 = req0_ready;
    chk("req0_ready", req0_ready, win == 0);
    chk("req1_ready", req1_ready, win == 1);
    chk("both_ready", req0_ready & req1_ready, 0);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    if (m_phase == 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      if (rr && rn) begin
        acc_id = rsp_id;
        acc_data = rsp_data;
        n_acc++;
        $display("rsp #%0d id=%0d data=%0d", n_acc, rsp_id, rsp_data);
      end
    end
    if (m_zero) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end
`ifdef ALU_RR_SCHED_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt[0]);
    chk("grant_cnt1", grant_cnt1, m_cnt[1]);
`endif
    // Advance the model across the coming rising edge
    m_zero = 1'b0;
    if (!rn) begin
      m_phase = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; m_zero = 1'b1;
    end else if (m_phase == 0) begin
      if (win >= 0) begin
        m_phase = 1;
        m_last = win;
        m_id = win;
        m_data = (win == 1) ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
        if (m_cnt[win] < CMAX) m_cnt[win]++;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rr) begin
      m_phase = 0;
    end
  endtask

  task automatic idle_step(input bit rr);
    step(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, rr);
  endtask

  int sweep_exp [4] = '{1, 1, 5, 6};

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    m_phase = 0; m_last = 1; m_id = 0; m_data = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_zero = 1'b1;
    n_acc = 0; acc_id = -1; acc_data = -1;
    repeat (2) @(posedge clk);

    // Single MUL request from requester 0
    step(1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0, '0, '0, 2'd0, 1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    chk("tp_mul_id", acc_id, 0);
    chk("tp_mul_data", acc_data, 9);

    // Opcode sweep on requester 1
    for (int op = 0; op < 4; op++) begin
      step(1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 2'd2, 2'd3, op[1:0], 1'b1);
      idle_step(1'b1);
      idle_step(1'b1);
      chk("tp_sweep_id", acc_id, 1);
      chk("tp_sweep_data", acc_data, sweep_exp[op]);
    end

    // Continuous contention
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, DW'(i), 2'd1, 2'd2, 1'b1, 2'd3, DW'(i), 2'd3, 1'b1);

    // Back-pressure held in RESP
    idle_step(1'b1);
    idle_step(1'b1);
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 2'd1, 2'd2, 2'd3, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0);
    step(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
    idle_step(1'b0);
    chk("bp_idle_busy", busy, 0);

    // Reset while computing
    idle_step(1'b1);
    step(1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 2'd1, 2'd1, 2'd3, 1'b1);
    step(1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 2'd1, 2'd1, 2'd2, 1'b1);
    step(1'b1, 1'b1, 2'd1, 2'd3, 2'd2, 1'b1, 2'd2, 2'd1, 2'd2, 1'b1);
    chk("rst_first_grant", seen_r0, 1);
    idle_step(1'b1);
    idle_step(1'b1);

`ifdef ALU_RR_SCHED_STATS_EN
    // Counter saturation
    step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, '0, '0, 2'd0, 1'b1);
      idle_step(1'b1);
      idle_step(1'b1);
    end
    chk("cnt0_sat", grant_cnt0, (5 < CMAX) ? 5 : CMAX);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           1'(($urandom_range(0, 2)) != 0), DW'($urandom), DW'($urandom), 2'($urandom),
           1'(($urandom_range(0, 2)) != 0), DW'($urandom), DW'($urandom), 2'($urandom),
           1'(($urandom_range(0, 3)) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
